// File: rtl/voq_rr_switch_pkg.sv
// Shared helpers for the VOQ round-robin switch.
// - sel_w:   width of a port index for a given port count
// - cnt_w:   width of an occupancy counter able to hold 0..depth
// - voq_idx: flat position of VOQ[input i][output j] in the per-VOQ buses
package voq_rr_switch_pkg;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int voq_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/voq_rr_switch_if.sv
// Bus bundle of the VOQ switch: input ports, output ports and status.
// master: traffic source/sink side (drives inputs, out_ready).
// slave:  the switch fabric.
interface voq_rr_switch_if
  import voq_rr_switch_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int SEL_W = sel_w(N_PORTS);

  logic [N_PORTS-1:0]            in_valid;
  logic [N_PORTS-1:0]            in_ready;
  logic [N_PORTS*SEL_W-1:0]      in_dest;
  logic [N_PORTS*DATA_WIDTH-1:0] in_data;
  logic [N_PORTS-1:0]            out_valid;
  logic [N_PORTS-1:0]            out_ready;
  logic [N_PORTS*DATA_WIDTH-1:0] out_data;
  logic [N_PORTS*SEL_W-1:0]      out_src;
  logic [N_PORTS*N_PORTS-1:0]    voq_empty;
  logic [N_PORTS*N_PORTS-1:0]    voq_full;
  logic [N_PORTS*CNT_WIDTH-1:0]  drop_cnt;

  modport master (
    output in_valid, in_dest, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, voq_empty, voq_full, drop_cnt
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, voq_empty, voq_full, drop_cnt
  );
endinterface

// File: rtl/voq_rr_switch_voq_fifo.sv
// One virtual output queue: synchronous FIFO with a registered count.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop (read),
// rdata (combinational head), full, empty (decoded from the count register).
// The caller never pushes when full nor pops when empty.
module voq_fifo
  import voq_rr_switch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
endmodule

// File: rtl/voq_rr_switch.sv
// N-port virtual-output-queued switch with a round-robin arbiter per output.
// Ports: clk, rst_n (async active-low), bus (voq_rr_switch_if.slave) carrying
// per-input valid/ready/dest/data, per-output valid/ready/data/src, VOQ
// empty/full flags (bit i*N_PORTS+j = VOQ[i][j]) and per-input drop counters.
module voq_rr_switch
  import voq_rr_switch_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  voq_rr_switch_if.slave bus
);
  localparam int SEL_W = sel_w(N_PORTS);
  localparam int NQ    = N_PORTS * N_PORTS;

  logic [NQ-1:0]                 push_s;
  logic [NQ-1:0]                 pop_s;
  logic [NQ-1:0]                 empty_s;
  logic [NQ-1:0]                 full_s;
  logic [DATA_WIDTH-1:0]         rdata_s [NQ];
  logic [N_PORTS-1:0]            in_ready_s;
  logic [N_PORTS-1:0]            drop_inc_s;
  logic [N_PORTS-1:0]            load_en_s;
  logic [N_PORTS-1:0]            found_s;
  logic [SEL_W-1:0]              grant_s [N_PORTS];
  logic [N_PORTS-1:0]            out_valid_r;
  logic [N_PORTS*DATA_WIDTH-1:0] out_data_r;
  logic [N_PORTS*SEL_W-1:0]      out_src_r;
  logic [SEL_W-1:0]              ptr_r [N_PORTS];
  logic [N_PORTS*CNT_WIDTH-1:0]  drop_cnt_r;

  for (genvar q = 0; q < NQ; q++) begin : g_voq
    voq_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_voq (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push_s[q]),
      .pop  (pop_s[q]),
      .wdata(bus.in_data[(q / N_PORTS) * DATA_WIDTH +: DATA_WIDTH]),
      .rdata(rdata_s[q]),
      .full (full_s[q]),
      .empty(empty_s[q])
    );
  end

  // Input side: ready, push steering and drop detection per input.
  always_comb begin
    logic [SEL_W-1:0] dest_v;
    logic             dest_ok_v;
    logic             tgt_full_v;
    push_s     = '0;
    drop_inc_s = '0;
    in_ready_s = '0;
    dest_v     = '0;
    dest_ok_v  = 1'b0;
    tgt_full_v = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      dest_v    = bus.in_dest[i*SEL_W +: SEL_W];
      dest_ok_v = (int'(dest_v) < N_PORTS);
      if (dest_ok_v) begin
        tgt_full_v = full_s[voq_idx(i, int'(dest_v), N_PORTS)];
      end else begin
        tgt_full_v = 1'b0;
      end
      // Ready uses the registered full flag only: a same-cycle pop does not help.
      if (DROP_ON_FULL != 0) begin
        in_ready_s[i] = rst_n;
      end else begin
        in_ready_s[i] = !tgt_full_v;
      end
      if (bus.in_valid[i] && in_ready_s[i]) begin
        if (dest_ok_v && !tgt_full_v) begin
          push_s[voq_idx(i, int'(dest_v), N_PORTS)] = 1'b1;
        end else begin
          drop_inc_s[i] = 1'b1;
        end
      end else begin
        drop_inc_s[i] = 1'b0;
      end
    end
  end

  // Round-robin grant per output column, searching upward from ptr+1.
  always_comb begin
    logic             hit_v;
    logic [SEL_W-1:0] g_v;
    int               idx_v;
    pop_s     = '0;
    load_en_s = '0;
    found_s   = '0;
    hit_v     = 1'b0;
    g_v       = '0;
    idx_v     = 0;
    for (int j = 0; j < N_PORTS; j++) begin
      grant_s[j] = '0;
    end
    for (int j = 0; j < N_PORTS; j++) begin
      load_en_s[j] = !out_valid_r[j] || bus.out_ready[j];
      hit_v        = 1'b0;
      g_v          = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
        idx_v = (int'(ptr_r[j]) + k) % N_PORTS;
        if (!hit_v && !empty_s[voq_idx(idx_v, j, N_PORTS)]) begin
          hit_v = 1'b1;
          g_v   = SEL_W'(idx_v);
        end else begin
          hit_v = hit_v;
        end
      end
      found_s[j] = hit_v;
      grant_s[j] = g_v;
      for (int i = 0; i < N_PORTS; i++) begin
        pop_s[voq_idx(i, j, N_PORTS)] = load_en_s[j] && hit_v && (g_v == SEL_W'(i));
      end
    end
  end

  // Output registers and arbiter pointers; a stalled output holds its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= '0;
      out_data_r  <= '0;
      out_src_r   <= '0;
      for (int j = 0; j < N_PORTS; j++) begin
        ptr_r[j] <= SEL_W'(N_PORTS - 1);
      end
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (load_en_s[j]) begin
          if (found_s[j]) begin
            out_valid_r[j]                       <= 1'b1;
            out_data_r[j*DATA_WIDTH +: DATA_WIDTH] <= rdata_s[voq_idx(int'(grant_s[j]), j, N_PORTS)];
            out_src_r[j*SEL_W +: SEL_W]          <= grant_s[j];
            ptr_r[j]                             <= grant_s[j];
          end else begin
            out_valid_r[j] <= 1'b0;
          end
        end
      end
    end
  end

  // Saturating per-input drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (drop_inc_s[i] && (drop_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}})) begin
          drop_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] <= drop_cnt_r[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.voq_empty = empty_s;
  assign bus.voq_full  = full_s;
  assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_voq_rr_switch.sv
// Directed bench: backpressure instance, drop-mode instance (2-bit counters to
// reach saturation) and a 3-port instance for out-of-range destinations.
module tb_voq_rr_switch;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  voq_rr_switch_if #(.N_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) bp_if ();
  voq_rr_switch_if #(.N_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(2))  dr_if ();
  voq_rr_switch_if #(.N_PORTS(3), .DATA_WIDTH(8), .CNT_WIDTH(16)) np_if ();

  voq_rr_switch #(.N_PORTS(4), .DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(0), .CNT_WIDTH(16))
    u_bp (.clk(clk), .rst_n(rst_n), .bus(bp_if.slave));
  voq_rr_switch #(.N_PORTS(4), .DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1), .CNT_WIDTH(2))
    u_dr (.clk(clk), .rst_n(rst_n), .bus(dr_if.slave));
  voq_rr_switch #(.N_PORTS(3), .DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(0), .CNT_WIDTH(16))
    u_np (.clk(clk), .rst_n(rst_n), .bus(np_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [7:0]  dest;
    logic [31:0] data;
    logic [3:0]  ev;
    int          port;
    logic [7:0]  ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic [3:0] iv, logic [7:0] dest, logic [31:0] data,
                              logic [3:0] ev, int port, logic [7:0] ed, logic [1:0] es);
    vec_t v;
    v.iv = iv; v.dest = dest; v.data = data;
    v.ev = ev; v.port = port; v.ed = ed; v.es = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bp_if.in_valid = '0; bp_if.in_dest = '0; bp_if.in_data = '0; bp_if.out_ready = 4'hF;
    dr_if.in_valid = '0; dr_if.in_dest = '0; dr_if.in_data = '0; dr_if.out_ready = 4'hF;
    np_if.in_valid = '0; np_if.in_dest = '0; np_if.in_data = '0; np_if.out_ready = 3'h7;

    // in0->out2 single word, then all four inputs streaming to out1
    tbl[0]  = mk(4'h0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 2'd0);
    tbl[1]  = mk(4'h1, 8'h02, 32'h000000A5, 4'h0, 0, 8'h00, 2'd0);
    tbl[2]  = mk(4'h0, 8'h00, 32'h0,        4'h4, 2, 8'hA5, 2'd0);
    tbl[3]  = mk(4'h0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 2'd0);
    tbl[4]  = mk(4'hF, 8'h55, 32'h13121110, 4'h0, 0, 8'h00, 2'd0);
    tbl[5]  = mk(4'hF, 8'h55, 32'h23222120, 4'h2, 1, 8'h10, 2'd0);
    tbl[6]  = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h11, 2'd1);
    tbl[7]  = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h12, 2'd2);
    tbl[8]  = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h13, 2'd3);
    tbl[9]  = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h20, 2'd0);
    tbl[10] = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h21, 2'd1);
    tbl[11] = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h22, 2'd2);
    tbl[12] = mk(4'h0, 8'h00, 32'h0,        4'h2, 1, 8'h23, 2'd3);
    tbl[13] = mk(4'h0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 2'd0);

    step();
    step();
    rst_n = 1'b1;
    step();

    // Idle after reset
    chk("rst_out_valid", 64'(bp_if.out_valid), 64'h0);
    chk("rst_out_data",  64'(bp_if.out_data),  64'h0);
    chk("rst_out_src",   64'(bp_if.out_src),   64'h0);
    chk("rst_voq_empty", 64'(bp_if.voq_empty), 64'hFFFF);
    chk("rst_voq_full",  64'(bp_if.voq_full),  64'h0);
    chk("rst_in_ready",  64'(bp_if.in_ready),  64'hF);
    chk("rst_drop_cnt",  64'(bp_if.drop_cnt),  64'h0);
    chk("rst_dr_ready",  64'(dr_if.in_ready),  64'hF);

    for (int v = 0; v < 14; v++) begin
      bp_if.in_valid = tbl[v].iv;
      bp_if.in_dest  = tbl[v].dest;
      bp_if.in_data  = tbl[v].data;
      step();
      chk($sformatf("vec%0d_valid", v), 64'(bp_if.out_valid), 64'(tbl[v].ev));
      if (tbl[v].ev[tbl[v].port]) begin
        chk($sformatf("vec%0d_data", v), 64'(bp_if.out_data[tbl[v].port*8 +: 8]), 64'(tbl[v].ed));
        chk($sformatf("vec%0d_src", v),  64'(bp_if.out_src[tbl[v].port*2 +: 2]),  64'(tbl[v].es));
      end
    end
    bp_if.in_valid = '0;

    // Backpressure: out3 stalled, in1 sends 30..34, sixth word sees not-ready
    bp_if.out_ready = 4'b0111;
    bp_if.in_dest   = 8'h0C;
    for (int w = 0; w < 5; w++) begin
      bp_if.in_valid = 4'b0010;
      bp_if.in_data  = 32'(8'h30 + w) << 8;
      chk($sformatf("bp_ready_w%0d", w), 64'(bp_if.in_ready[1]), 64'h1);
      step();
    end
    bp_if.in_data = 32'h00003500;
    #1;
    chk("bp_ready_full", 64'(bp_if.in_ready[1]), 64'h0);
    chk("bp_voq_full7",  64'(bp_if.voq_full[7]), 64'h1);
    chk("bp_out_valid3", 64'(bp_if.out_valid[3]), 64'h1);
    chk("bp_out_data3",  64'(bp_if.out_data[31:24]), 64'h30);
    chk("bp_out_src3",   64'(bp_if.out_src[7:6]), 64'h1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("stall%0d_data", c), 64'(bp_if.out_data[31:24]), 64'h30);
      chk($sformatf("stall%0d_src", c),  64'(bp_if.out_src[7:6]), 64'h1);
      chk($sformatf("stall%0d_full", c), 64'(bp_if.voq_full[7]), 64'h1);
    end
    bp_if.in_valid  = '0;
    bp_if.out_ready = 4'hF;
    for (int w = 1; w < 5; w++) begin
      step();
      chk($sformatf("bp_drain%0d_valid", w), 64'(bp_if.out_valid[3]), 64'h1);
      chk($sformatf("bp_drain%0d_data", w),  64'(bp_if.out_data[31:24]), 64'(8'h30 + w));
    end
    step();
    chk("bp_drain_done", 64'(bp_if.out_valid[3]), 64'h0);

    // Simultaneous push/pop on VOQ[2][0]: occupancy stays at one
    bp_if.in_dest = 8'h00;
    for (int c = 0; c < 6; c++) begin
      bp_if.in_valid = 4'b0100;
      bp_if.in_data  = 32'(8'h40 + c) << 16;
      step();
      chk($sformatf("pp%0d_empty8", c), 64'(bp_if.voq_empty[8]), 64'h0);
      if (c >= 1) begin
        chk($sformatf("pp%0d_data", c), 64'(bp_if.out_data[7:0]), 64'(8'h40 + c - 1));
      end
    end
    bp_if.in_valid = '0;
    step();
    chk("pp_last_data", 64'(bp_if.out_data[7:0]), 64'h45);
    chk("pp_empty8",    64'(bp_if.voq_empty[8]), 64'h1);
    step();
    chk("pp_idle", 64'(bp_if.out_valid[0]), 64'h0);

    // Drop mode: 9 words into a 4-deep VOQ behind a stalled output
    dr_if.out_ready = 4'b0111;
    dr_if.in_dest   = 8'h0C;
    for (int w = 0; w < 9; w++) begin
      dr_if.in_valid = 4'b0010;
      dr_if.in_data  = 32'(8'h50 + w) << 8;
      chk($sformatf("dr_ready_w%0d", w), 64'(dr_if.in_ready[1]), 64'h1);
      step();
      if (w == 6) begin
        chk("dr_cnt_two", 64'(dr_if.drop_cnt), 64'h08);
      end
    end
    chk("dr_cnt_sat", 64'(dr_if.drop_cnt), 64'h0C);
    dr_if.in_valid = '0;
    chk("dr_head_data", 64'(dr_if.out_data[31:24]), 64'h50);
    chk("dr_head_src",  64'(dr_if.out_src[7:6]), 64'h1);
    dr_if.out_ready = 4'hF;
    for (int w = 1; w < 5; w++) begin
      step();
      chk($sformatf("dr_drain%0d_data", w), 64'(dr_if.out_data[31:24]), 64'(8'h50 + w));
    end
    step();
    chk("dr_drain_done", 64'(dr_if.out_valid[3]), 64'h0);

    // 3-port switch: destination 3 does not exist
    np_if.in_valid = 3'b001;
    np_if.in_dest  = 6'h03;
    #1;
    chk("np_ready_bad", 64'(np_if.in_ready[0]), 64'h1);
    step();
    chk("np_drop_cnt", 64'(np_if.drop_cnt[15:0]), 64'h1);
    chk("np_empty",    64'(np_if.voq_empty), 64'h1FF);
    np_if.in_valid = 3'b010;
    np_if.in_dest  = 6'h08;
    np_if.in_data  = 24'h007700;
    step();
    np_if.in_valid = '0;
    step();
    chk("np_valid", 64'(np_if.out_valid), 64'h4);
    chk("np_data",  64'(np_if.out_data[23:16]), 64'h77);
    chk("np_src",   64'(np_if.out_src[5:4]), 64'h1);

    // Partially fill every column with outputs stalled, then reset mid-cycle
    bp_if.out_ready = 4'h0;
    bp_if.in_dest   = 8'h39;
    bp_if.in_data   = 32'h83828180;
    for (int c = 0; c < 3; c++) begin
      bp_if.in_valid = 4'hF;
      step();
    end
    bp_if.in_valid = '0;
    chk("pre_rst_empty", 64'(bp_if.voq_empty), 64'hE7BD);
    chk("pre_rst_valid", 64'(bp_if.out_valid), 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty",    64'(bp_if.voq_empty), 64'hFFFF);
    chk("arst_full",     64'(bp_if.voq_full),  64'h0);
    chk("arst_valid",    64'(bp_if.out_valid), 64'h0);
    chk("arst_data",     64'(bp_if.out_data),  64'h0);
    chk("arst_src",      64'(bp_if.out_src),   64'h0);
    chk("arst_dr_cnt",   64'(dr_if.drop_cnt),  64'h0);
    chk("arst_dr_ready", 64'(dr_if.in_ready),  64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bp_if.out_ready = 4'hF;
    bp_if.in_valid  = 4'b1001;
    bp_if.in_dest   = 8'hC3;
    bp_if.in_data   = 32'h63000060;
    step();
    bp_if.in_valid = '0;
    step();
    chk("post_rst_src0",  64'(bp_if.out_src[7:6]), 64'h0);
    chk("post_rst_data0", 64'(bp_if.out_data[31:24]), 64'h60);
    step();
    chk("post_rst_src3",  64'(bp_if.out_src[7:6]), 64'h3);
    chk("post_rst_data3", 64'(bp_if.out_data[31:24]), 64'h63);
    step();
    chk("post_rst_idle",  64'(bp_if.out_valid[3]), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
